mux2a1_arb: RTL and testbench
=============================

Name: mux2a1_arb

Overview:
- Round-robin arbiter and controller that sits directly upstream of the 2:1 multiplexer.
- Two requesters (X, Y) compete for the shared mux path.
- The block generates the mux select (Sel) and one-hot grants.
- It registers the selected data into Yout with a Valid flag for the downstream consumer.
- Each grant is held for at most DWELL cycles, so neither channel can starve the other.

Parameters:
- WIDTH, 1: data width of X, Y and Yout.
- DWELL, 4: maximum consecutive cycles one channel may hold the grant (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ReqX  input  1  channel X request; level, held while X has data.
- ReqY  input  1  channel Y request; level, held while Y has data.
- X  input  WIDTH  channel X data.
- Y  input  WIDTH  channel Y data.
- Sel  output  1  mux select: 0 selects X, 1 selects Y; registered.
- GntX  output  1  grant to X; registered; one-hot with GntY.
- GntY  output  1  grant to Y; registered; one-hot with GntX.
- Yout  output  WIDTH  registered copy of the selected data.
- Valid  output  1  Yout holds granted data this cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, Sel=0, GntX=0, GntY=0, Yout=0, Valid=0, dwell counter=0, Last=Y (so X wins the first tie).
- Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- States: IDLE, SERV_X, SERV_Y.
  - Registered outputs: GntX=1 only in SERV_X; GntY=1 only in SERV_Y.
  - Sel=1 in SERV_Y, Sel=0 in SERV_X. Sel holds its previous value in IDLE.
- Arbitration at a decision point (IDLE, or leaving a SERV state):
  - Both requesting: grant the channel not equal to Last.
  - Exactly one requesting: grant that channel.
  - None requesting: go to IDLE.
  - Last updates to the granted channel on each entry to SERV_X/SERV_Y.
- Dwell counter:
  - Cleared on every entry to a SERV state, including re-entry to the same state.
  - Increments every cycle spent in a SERV state.
- Leaving SERV_x (x = X or Y) happens at the edge where either:
  - Reqx is sampled 0, or
  - the counter equals DWELL-1 (grant expiry).
- On leaving SERV_x:
  - If the other channel is requesting, move to the other SERV state.
  - Else, if Reqx is still 1 (expiry with no competitor), re-enter SERV_x with the counter cleared; grant stays continuous.
  - Else, go to IDLE.
- Grant latency: a request sampled at edge n in IDLE gives the grant high after edge n.
- Data path:
  - Each cycle, Yout <= (state==SERV_Y) ? Y : X and Valid <= (state != IDLE).
  - Yout and Valid therefore lag the grant by exactly 1 cycle.
  - In IDLE, Yout holds its last value and Valid=0.
- Request drop: a dropped request is seen at the next edge. One extra granted cycle after the drop is permitted; Valid covers that cycle.
- DWELL=1: the grant alternates every cycle while both channels request; a lone requester keeps a continuous grant.
- GntX and GntY are never both 1. Sel always equals GntY whenever a grant is active.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle while in SERV_Y -> Sel=0, GntX=0, GntY=0, Yout=0, Valid=0 immediately. After release, ReqX=1 -> GntX=1 one edge later.
- Lone requester: ReqX=1, ReqY=0, X=1, DWELL=4 for 10 cycles -> GntX continuously 1, Sel=0; Yout=1 and Valid=1 starting one cycle after GntX; GntY never 1.
- Contention: ReqX=ReqY=1 from reset, DWELL=4 -> GntX for 4 cycles, then GntY for 4, then GntX for 4, and so on; Sel follows GntY; Yout tracks X/Y one cycle late.
- Early release: both requesting, X granted, ReqX drops after 2 cycles -> switch to SERV_Y on the next edge; counter restarts, so Y gets a full 4 cycles.
- Tie fairness after idle: Y served last, both drop to IDLE, then ReqX=ReqY=1 in the same cycle -> X granted first.
- DWELL=1 corner: ReqX=ReqY=1, X=0, Y=1 -> Sel toggles 0,1,0,1 each cycle; Yout = 0,1,0,1 delayed one cycle; Valid stays 1.

Source files
------------

// File: rtl/mux2a1_arb_if.sv
// Request/data/grant bundle between two requesters and the mux2a1_arb controller.
// master drives requests and data; slave (the arbiter) drives select, grants and output data.
interface mux2a1_arb_if #(
  parameter int WIDTH = 1
);
  logic             ReqX;
  logic             ReqY;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Sel;
  logic             GntX;
  logic             GntY;
  logic [WIDTH-1:0] Yout;
  logic             Valid;

  modport master (
    output ReqX, ReqY, X, Y,
    input  Sel, GntX, GntY, Yout, Valid
  );

  modport slave (
    input  ReqX, ReqY, X, Y,
    output Sel, GntX, GntY, Yout, Valid
  );
endinterface

// File: rtl/mux2a1_arb.sv
// Two-channel round-robin arbiter with dwell limit, driving a 2:1 mux select
// and a registered copy of the selected data one cycle behind the grant.
module mux2a1_arb #(
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux2a1_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_X = 2'd1,
    SERV_Y = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t           r_state;
  logic             r_last_y;
  logic [7:0]       r_cnt;
  logic             r_sel;
  logic             r_gnt_x;
  logic             r_gnt_y;
  logic [WIDTH-1:0] r_yout;
  logic             r_valid;

  state_t           w_next;
  logic             w_decide;

  // At a decision point the holder is always the last-served channel, so the
  // same tie-break rule yields "hand over to the competitor" when leaving SERV.
  function automatic state_t pick(input logic req_x, input logic req_y,
                                  input logic last_y);
    state_t res;
    res = IDLE;
    if (req_x && req_y) res = last_y ? SERV_X : SERV_Y;
    else if (req_x)     res = SERV_X;
    else if (req_y)     res = SERV_Y;
    return res;
  endfunction

  always_comb begin
    w_next   = r_state;
    w_decide = 1'b1;
    case (r_state)
      SERV_X:  w_decide = !bus.ReqX || (r_cnt == CNT_LAST);
      SERV_Y:  w_decide = !bus.ReqY || (r_cnt == CNT_LAST);
      default: w_decide = 1'b1;
    endcase
    if (w_decide) w_next = pick(bus.ReqX, bus.ReqY, r_last_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_y <= 1'b1;
      r_cnt    <= '0;
      r_sel    <= 1'b0;
      r_gnt_x  <= 1'b0;
      r_gnt_y  <= 1'b0;
      r_yout   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Any grant decision restarts the dwell window, even a same-channel re-entry.
      if (w_decide && (w_next != IDLE)) begin
        r_cnt    <= '0;
        r_last_y <= (w_next == SERV_Y);
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_gnt_x <= (w_next == SERV_X);
      r_gnt_y <= (w_next == SERV_Y);
      if (w_next != IDLE) r_sel <= (w_next == SERV_Y);
      // Data stage follows the current grant, so it trails the grant by one cycle.
      r_valid <= (r_state != IDLE);
      if (r_state != IDLE) r_yout <= (r_state == SERV_Y) ? bus.Y : bus.X;
    end
  end

  assign bus.Sel   = r_sel;
  assign bus.GntX  = r_gnt_x;
  assign bus.GntY  = r_gnt_y;
  assign bus.Yout  = r_yout;
  assign bus.Valid = r_valid;

endmodule

// File: tb/tb_mux2a1_arb.sv
// Bench for mux2a1_arb: DWELL=4 and DWELL=1 instances share stimulus and are
// compared each cycle against a grant-ownership model of the arbitration rules.
module tb_mux2a1_arb;
  localparam int W  = 4;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         reqx = 1'b0;
  logic         reqy = 1'b0;
  logic [W-1:0] xd   = '0;
  logic [W-1:0] yd   = '0;

  mux2a1_arb_if #(.WIDTH(W)) bus4 ();
  mux2a1_arb_if #(.WIDTH(W)) bus1 ();

  assign bus4.ReqX = reqx;
  assign bus4.ReqY = reqy;
  assign bus4.X    = xd;
  assign bus4.Y    = yd;
  assign bus1.ReqX = reqx;
  assign bus1.ReqY = reqy;
  assign bus1.X    = xd;
  assign bus1.Y    = yd;

  mux2a1_arb #(.WIDTH(W), .DWELL(D0)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux2a1_arb #(.WIDTH(W), .DWELL(D1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [W+3:0] act [2];
  assign act[0] = {bus4.Sel, bus4.GntX, bus4.GntY, bus4.Valid, bus4.Yout};
  assign act[1] = {bus1.Sel, bus1.GntX, bus1.GntY, bus1.Valid, bus1.Yout};

  int checks = 0;
  int errors = 0;

  // Model: owner 0=none, 1=X, 2=Y; held = cycles granted in current window.
  int           dw     [2] = '{D0, D1};
  int           m_own  [2];
  int           m_held [2];
  int           m_last [2];
  logic         m_sel  [2];
  logic         m_valid[2];
  logic [W-1:0] m_yout [2];

  function automatic int pick(bit rx, bit ry, int last);
    if (rx && ry) return (last == 1) ? 2 : 1;
    if (rx) return 1;
    if (ry) return 2;
    return 0;
  endfunction

  function automatic logic [W+3:0] exp_vec(int k);
    return {m_sel[k], (m_own[k] == 1), (m_own[k] == 2), m_valid[k], m_yout[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_held[k] = 0; m_last[k] = 2;
      m_sel[k] = 1'b0; m_valid[k] = 1'b0; m_yout[k] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit decide;
      int n;
      decide = (m_own[k] == 0) || (m_own[k] == 1 && !reqx) ||
               (m_own[k] == 2 && !reqy) || (m_held[k] == dw[k]);
      if (m_own[k] != 0) begin
        m_yout[k]  = (m_own[k] == 2) ? yd : xd;
        m_valid[k] = 1'b1;
      end else begin
        m_valid[k] = 1'b0;
      end
      if (decide) begin
        n = pick(reqx, reqy, m_last[k]);
        if (n != 0) begin m_last[k] = n; m_held[k] = 1; end
      end else begin
        n = m_own[k];
        m_held[k]++;
      end
      m_own[k] = n;
      if (n == 1) m_sel[k] = 1'b0;
      if (n == 2) m_sel[k] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reqx = 1'b0; reqy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== '0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got %h want 0", k, act[k]);
      end
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_idle inst=%0d cyc=%0d got %h want %h", k, i, act[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_lone();
    do_reset();
    reqx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      xd = W'($urandom); yd = W'($urandom);
      step();
      checks++;
      if (bus4.GntX !== 1'b1 || bus4.GntY !== 1'b0 || bus4.Sel !== 1'b0) begin
        errors++;
        $display("FAIL lone_grant cyc=%0d got gx=%b gy=%b sel=%b want 1 0 0", i, bus4.GntX, bus4.GntY, bus4.Sel);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL lone inst=%0d cyc=%0d got %h want %h", k, i, act[k], exp_vec(k));
        end
      end
    end
    reqx = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    reqx = 1'b1; reqy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xd = W'($urandom); yd = W'($urandom);
      step();
      checks++;
      if (bus4.GntX !== 1'(((i / D0) % 2) == 0) || bus4.Sel !== bus4.GntY) begin
        errors++;
        $display("FAIL contention_rr cyc=%0d got gx=%b sel=%b want gx=%b", i, bus4.GntX, bus4.Sel, ((i / D0) % 2) == 0);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL contention inst=%0d cyc=%0d got %h want %h", k, i, act[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    reqx = 1'b1; reqy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      xd = W'($urandom); yd = W'($urandom);
      if (i == 2) reqx = 1'b0;
      if (i == 3) reqx = 1'b1;
      step();
      if (i >= 2 && i <= 5) begin
        checks++;
        if (bus4.GntY !== 1'b1) begin
          errors++;
          $display("FAIL early_release_y cyc=%0d got gy=%b want 1", i, bus4.GntY);
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL early_release inst=%0d cyc=%0d got %h want %h", k, i, act[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_tie_after_idle();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 7; i++) begin
        reqx = (pass == 1) && (i < 3);
        reqy = (pass == 0) && (i < 3);
        if (i >= 5) begin reqx = 1'b1; reqy = 1'b1; end
        xd = W'($urandom); yd = W'($urandom);
        step();
        if (i == 5) begin
          checks++;
          if (bus4.GntX !== 1'(pass == 0) || bus4.GntY !== 1'(pass == 1)) begin
            errors++;
            $display("FAIL tie_after_idle pass=%0d got gx=%b gy=%b want gx=%b", pass, bus4.GntX, bus4.GntY, pass == 0);
          end
        end
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (act[k] !== exp_vec(k)) begin
            errors++;
            $display("FAIL tie inst=%0d pass=%0d cyc=%0d got %h want %h", k, pass, i, act[k], exp_vec(k));
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    reqy = 1'b1; yd = 4'h9; xd = 4'h6;
    repeat (3) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== '0) begin
        errors++;
        $display("FAIL async_reset inst=%0d got %h want 0", k, act[k]);
      end
    end
    #1 rst_n = 1'b1;
    reqy = 1'b0; reqx = 1'b1;
    step();
    checks++;
    if (bus4.GntX !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant got gx=%b want 1", bus4.GntX);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL post_reset inst=%0d got %h want %h", k, act[k], exp_vec(k));
      end
    end
    reqx = 1'b0;
  endtask

  task automatic test_dwell1();
    do_reset();
    xd = 4'h0; yd = 4'h1;
    reqx = 1'b1; reqy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus1.Sel !== 1'(i % 2)) begin
        errors++;
        $display("FAIL dwell1_sel cyc=%0d got %b want %b", i, bus1.Sel, i % 2);
      end
      if (i >= 1) begin
        checks++;
        if (bus1.Valid !== 1'b1 || bus1.Yout !== W'((i - 1) % 2)) begin
          errors++;
          $display("FAIL dwell1_data cyc=%0d got v=%b y=%h want v=1 y=%0d", i, bus1.Valid, bus1.Yout, (i - 1) % 2);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) reqx = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) reqy = ($urandom_range(0, 2) != 0);
      xd = W'($urandom); yd = W'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== exp_vec(k) || (act[k][W+2] & act[k][W+1])) begin
          errors++;
          $display("FAIL random inst=%0d cyc=%0d got %h want %h", k, i, act[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_lone();
    test_contention();
    test_early_release();
    test_tie_after_idle();
    test_async_reset();
    test_dwell1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
